axis_width_upsizer: RTL and testbench

//  Single-clock AXI-Stream width upsizer placed directly downstream of the AXIS data FIFO's master port.

---
 rtl/axis_width_upsizer.sv | 86 ++++++++
 tb/tb_axis_width_upsizer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_width_upsizer.sv
// Packs RATIO narrow AXIS beats into one wide beat. The first beat lands in lane 0.
// The wide beat is valid 1 cycle after the last narrow beat is taken. Input stalls only when the last lane is pending behind a stalled output.
module axis_width_upsizer #(
  parameter int IN_WIDTH = 32,
  parameter int RATIO    = 4
) (
  input  logic                          axis_clk,
  input  logic                          axis_rst_n,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [IN_WIDTH-1:0]           s_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [IN_WIDTH*RATIO-1:0]     m_axis_tdata,
  output logic [$clog2(RATIO)-1:0]      lane_cnt
);

  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int CNT_W     = $clog2(RATIO);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0]               cnt;
  logic [RATIO-2:0][IN_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0]           out_dat;
  logic                           out_vld;
  logic                           rdy_en;
  logic                           cnt_last;
  logic                           in_hs;
  logic                           load;
  logic                           drain;

  // Only the final lane needs the output register free; earlier lanes go to the accumulator.
  assign cnt_last      = (cnt == CNT_LAST);
  assign s_axis_tready = rdy_en && (!cnt_last || !out_vld || m_axis_tready);
  assign in_hs         = s_axis_tvalid && s_axis_tready;
  assign load          = in_hs && cnt_last;
  assign drain         = out_vld && m_axis_tready;

  // Holds off input acceptance until the first edge after reset release.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      cnt <= '0;
    end else if (in_hs) begin
      cnt <= cnt_last ? '0 : cnt + CNT_W'(1);
    end
  end

  // Lanes are not cleared on wrap; every lane is rewritten before the next load uses it.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      acc <= '0;
    end else begin
      for (int k = 0; k < RATIO - 1; k++) begin
        if (in_hs && !cnt_last && (cnt == CNT_W'(k))) begin
          acc[k] <= s_axis_tdata;
        end
      end
    end
  end

  // A load overrides a drain, so back-to-back wide beats keep tvalid high.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      out_dat <= '0;
      out_vld <= 1'b0;
    end else if (load) begin
      out_dat <= {s_axis_tdata, acc};
      out_vld <= 1'b1;
    end else if (drain) begin
      out_vld <= 1'b0;
    end
  end

  assign m_axis_tvalid = out_vld;
  assign m_axis_tdata  = out_dat;
  assign lane_cnt      = cnt;

endmodule

// File: tb/tb_axis_width_upsizer.sv
// Scoreboard bench: a 32x4 instance for directed tests and an 8x2 instance for random traffic.
// Expected wide beats are queued when issued; per-instance monitors pop and compare on handshake.
module tb_axis_width_upsizer;

  logic         clk;
  logic         rst_n;

  logic         a_s_vld, a_s_rdy, a_m_vld, a_m_rdy;
  logic [31:0]  a_s_dat;
  logic [127:0] a_m_dat;
  logic [1:0]   a_lane;

  logic         b_s_vld, b_s_rdy, b_m_vld, b_m_rdy;
  logic [7:0]   b_s_dat;
  logic [15:0]  b_m_dat;
  logic         b_lane;

  logic [127:0] exp_a[$];
  logic [15:0]  exp_b[$];

  int checks = 0;
  int errors = 0;
  int a_pops = 0;
  int a_stalls = 0;
  int cyc = 0;
  bit a_done = 0;
  bit b_done = 0;

  axis_width_upsizer #(.IN_WIDTH(32), .RATIO(4)) u_dut_a (
    .axis_clk(clk), .axis_rst_n(rst_n),
    .s_axis_tvalid(a_s_vld), .s_axis_tready(a_s_rdy), .s_axis_tdata(a_s_dat),
    .m_axis_tvalid(a_m_vld), .m_axis_tready(a_m_rdy), .m_axis_tdata(a_m_dat),
    .lane_cnt(a_lane)
  );

  axis_width_upsizer #(.IN_WIDTH(8), .RATIO(2)) u_dut_b (
    .axis_clk(clk), .axis_rst_n(rst_n),
    .s_axis_tvalid(b_s_vld), .s_axis_tready(b_s_rdy), .s_axis_tdata(b_s_dat),
    .m_axis_tvalid(b_m_vld), .m_axis_tready(b_m_rdy), .m_axis_tdata(b_m_dat),
    .lane_cnt(b_lane)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic send_a(input logic [31:0] d);
    bit hs;
    hs = 0;
    a_s_vld = 1'b1;
    a_s_dat = d;
    for (int n = 0; n < 500 && !hs; n++) begin
      #1;
      hs = a_s_rdy;
      if (!hs) a_stalls++;
      @(negedge clk);
    end
    if (!hs) begin
      checks++;
      errors++;
      $display("FAIL a_send_timeout data %0h never accepted", d);
    end
  endtask

  task automatic send_b(input logic [7:0] d);
    bit hs;
    hs = 0;
    b_s_vld = 1'b1;
    b_s_dat = d;
    for (int n = 0; n < 500 && !hs; n++) begin
      #1;
      hs = b_s_rdy;
      @(negedge clk);
    end
    if (!hs) begin
      checks++;
      errors++;
      $display("FAIL b_send_timeout data %0h never accepted", d);
    end
  endtask

  task automatic idle_a();
    a_s_vld = 1'b0;
    a_s_dat = 'x;
    @(negedge clk);
  endtask

  task automatic idle_b();
    b_s_vld = 1'b0;
    b_s_dat = 'x;
    @(negedge clk);
  endtask

  task automatic wait_empty(input string name);
    a_s_vld = 1'b0;
    b_s_vld = 1'b0;
    for (int n = 0; n < 300 && (exp_a.size() != 0 || exp_b.size() != 0); n++) @(negedge clk);
    chk({name, "_a_left"}, 128'(exp_a.size()), 128'd0);
    chk({name, "_b_left"}, 128'(exp_b.size()), 128'd0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor A: pops on handshake and checks AXIS hold while stalled.
  initial begin
    bit pv;
    logic [127:0] pd, e;
    pv = 0;
    pd = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        pv = 0;
        continue;
      end
      if (pv) begin
        chk("a_stall_vld", 128'(a_m_vld), 128'd1);
        chk("a_stall_dat", a_m_dat, pd);
      end
      pv = a_m_vld && !a_m_rdy;
      pd = a_m_dat;
      if (a_m_vld && a_m_rdy) begin
        a_pops++;
        if (exp_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected got %0h expected none", a_m_dat);
        end else begin
          e = exp_a.pop_front();
          chk("a_data", a_m_dat, e);
        end
      end
    end
  end

  initial begin
    bit pv;
    logic [15:0] pd, e;
    pv = 0;
    pd = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        pv = 0;
        continue;
      end
      if (pv) begin
        chk("b_stall_vld", 128'(b_m_vld), 128'd1);
        chk("b_stall_dat", 128'(b_m_dat), 128'(pd));
      end
      pv = b_m_vld && !b_m_rdy;
      pd = b_m_dat;
      if (b_m_vld && b_m_rdy) begin
        if (exp_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected got %0h expected none", b_m_dat);
        end else begin
          e = exp_b.pop_front();
          chk("b_data", 128'(b_m_dat), 128'(e));
        end
      end
    end
  end

  initial begin
    int p0, c0;
    logic [127:0] wa;
    logic [31:0]  da;
    logic [15:0]  wb;
    logic [7:0]   db;

    rst_n = 1'b1;
    a_s_vld = 1'b0; a_s_dat = '0; a_m_rdy = 1'b0;
    b_s_vld = 1'b0; b_s_dat = '0; b_m_rdy = 1'b0;
    #2 rst_n = 1'b0;

    // 1: reset with random inputs
    repeat (4) begin
      @(negedge clk);
      a_s_vld = 1'($urandom_range(0, 1)); a_s_dat = $urandom; a_m_rdy = 1'($urandom_range(0, 1));
      b_s_vld = 1'($urandom_range(0, 1)); b_s_dat = 8'($urandom); b_m_rdy = 1'($urandom_range(0, 1));
      #1;
      chk("rst_a_vld", 128'(a_m_vld), 128'd0);
      chk("rst_a_dat", a_m_dat, 128'd0);
      chk("rst_a_lane", 128'(a_lane), 128'd0);
      chk("rst_b_vld", 128'(b_m_vld), 128'd0);
    end
    @(negedge clk);
    a_s_vld = 1'b0; b_s_vld = 1'b0; a_m_rdy = 1'b1; b_m_rdy = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_a_rdy_after", 128'(a_s_rdy), 128'd1);
    chk("rst_b_rdy_after", 128'(b_s_rdy), 128'd1);
    @(negedge clk);

    // 2: pack order and one-cycle latency
    p0 = a_pops;
    exp_a.push_back(128'h00000044_00000033_00000022_00000011);
    send_a(32'h11);
    send_a(32'h22);
    send_a(32'h33);
    send_a(32'h44);
    a_s_vld = 1'b0;
    #1;
    chk("pack_latency_vld", 128'(a_m_vld), 128'd1);
    @(negedge clk);
    wait_empty("pack");
    chk("pack_pops", 128'(a_pops - p0), 128'd1);
    chk("pack_lane", 128'(a_lane), 128'd0);

    // 3: continuous throughput, 400 narrow beats
    p0 = a_pops;
    a_stalls = 0;
    c0 = cyc;
    for (int g = 0; g < 100; g++) begin
      for (int k = 0; k < 4; k++) begin
        da = {8'(g), 8'(k), 16'hC0DE ^ 16'(g * 7)};
        wa[k*32 +: 32] = da;
      end
      exp_a.push_back(wa);
      for (int k = 0; k < 4; k++) send_a(wa[k*32 +: 32]);
    end
    chk("thru_cycles", 128'(cyc - c0), 128'd400);
    chk("thru_stalls", 128'(a_stalls), 128'd0);
    wait_empty("thru");
    chk("thru_pops", 128'(a_pops - p0), 128'd100);

    // 4: backpressure
    p0 = a_pops;
    a_m_rdy = 1'b0;
    exp_a.push_back(128'h000000A3_000000A2_000000A1_000000A0);
    exp_a.push_back(128'h000000A7_000000A6_000000A5_000000A4);
    for (int k = 0; k < 7; k++) send_a(32'hA0 + 32'(k));
    a_s_vld = 1'b1;
    a_s_dat = 32'hA7;
    repeat (3) begin
      #1;
      chk("bp_s_rdy", 128'(a_s_rdy), 128'd0);
      chk("bp_lane", 128'(a_lane), 128'd3);
      chk("bp_m_vld", 128'(a_m_vld), 128'd1);
      chk("bp_m_dat", a_m_dat, 128'h000000A3_000000A2_000000A1_000000A0);
      @(negedge clk);
    end
    a_m_rdy = 1'b1;
    send_a(32'hA7);
    wait_empty("bp");
    chk("bp_pops", 128'(a_pops - p0), 128'd2);

    // 5: reset mid-packet
    send_a(32'hDEAD0001);
    send_a(32'hDEAD0002);
    idle_a();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_lane", 128'(a_lane), 128'd0);
    chk("mid_rst_vld", 128'(a_m_vld), 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    p0 = a_pops;
    exp_a.push_back(128'h000000B3_000000B2_000000B1_000000B0);
    for (int k = 0; k < 4; k++) send_a(32'hB0 + 32'(k));
    wait_empty("mid");
    chk("mid_pops", 128'(a_pops - p0), 128'd1);

    // 6: random valid/ready on both ratios
    fork
      begin
        for (int g = 0; g < 2500; g++) begin
          for (int k = 0; k < 4; k++) wa[k*32 +: 32] = $urandom;
          exp_a.push_back(wa);
          for (int k = 0; k < 4; k++) begin
            while ($urandom_range(0, 1) == 1) idle_a();
            send_a(wa[k*32 +: 32]);
          end
        end
        a_s_vld = 1'b0;
        a_done = 1;
      end
      begin
        for (int g = 0; g < 5000; g++) begin
          for (int k = 0; k < 2; k++) begin
            db = 8'($urandom);
            wb[k*8 +: 8] = db;
          end
          exp_b.push_back(wb);
          for (int k = 0; k < 2; k++) begin
            while ($urandom_range(0, 1) == 1) idle_b();
            send_b(wb[k*8 +: 8]);
          end
        end
        b_s_vld = 1'b0;
        b_done = 1;
      end
      begin
        while (!(a_done && b_done)) begin
          @(negedge clk);
          a_m_rdy = 1'($urandom_range(0, 1));
          b_m_rdy = 1'($urandom_range(0, 1));
        end
      end
    join
    @(negedge clk);
    a_m_rdy = 1'b1;
    b_m_rdy = 1'b1;
    wait_empty("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
